// File: rtl/neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module      : neuron_feeder
// Description : Initiator for the 9-input Neurone MAC block. Holds a writable
//               weight bank and collects N_IN input samples from a
//               valid/ready stream. It then fires a single start pulse into
//               Neurone, waits (bounded) for its done flag, and returns the
//               captured result on a valid/ready result port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_IN     inputs per neuron (weight/sample indices 0..N_IN-1, N_IN <= 16)
//   IN_W     signed input sample width, also the Neurone result width
//   W_W      signed weight width
//   TIMEOUT  maximum number of cycles spent waiting for Neurone done
// Ports
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   w_we        weight write strobe
//   w_addr      weight index; indices >= N_IN are ignored
//   w_data      weight value
//   s_valid     input sample valid
//   s_ready     input sample ready (high only while collecting)
//   s_data      input sample
//   n_input     packed samples to Neurone, slice [k*IN_W +: IN_W]
//   n_weight    packed weights to Neurone, slice [k*W_W +: W_W]
//   n_start_    one-cycle start pulse to Neurone (registered)
//   n_out       Neurone result
//   n_end_      Neurone done, active high
//   r_valid     result valid
//   r_ready     result consumer ready
//   r_data      captured result
//   busy        high whenever the controller is not collecting
//   timeout_err sticky Neurone timeout flag, cleared only by reset
// ============================================================================
module neuron_feeder #(
    parameter int N_IN    = 9,
    parameter int IN_W    = 100,
    parameter int W_W     = 33,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // weight bank write port
    input  logic                 w_we,
    input  logic [3:0]           w_addr,
    input  logic [W_W-1:0]       w_data,
    // input sample stream
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_W-1:0]      s_data,
    // Neurone interface
    output logic [N_IN*IN_W-1:0] n_input,
    output logic [N_IN*W_W-1:0]  n_weight,
    output logic                 n_start_,
    input  logic [IN_W-1:0]      n_out,
    input  logic                 n_end_,
    // result stream
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [IN_W-1:0]      r_data,
    // status
    output logic                 busy,
    output logic                 timeout_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FIRE    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Sample index width; the weight address is a 4-bit port, so the bank
    // index is taken from its low IDX_W bits once the range check passes.
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    // Wait counter must be able to hold TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             start_q,  start_d;
    logic             rvalid_q, rvalid_d;
    logic             terr_q,   terr_d;
    logic [IN_W-1:0]  rdata_q,  rdata_d;

    logic [W_W-1:0]   weight_q [N_IN];
    logic [IN_W-1:0]  sample_q [N_IN];

    logic             s_accept;
    logic             w_write_ok;

    // Back-pressure is total outside COLLECT, so the sample registers (and
    // hence n_input) cannot move between FIRE and the next collection.
    assign s_ready    = (state_q == ST_COLLECT);
    assign s_accept   = s_valid && s_ready;
    assign w_write_ok = w_we && (int'(w_addr) < N_IN);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        rvalid_d = rvalid_q;
        terr_d   = terr_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_COLLECT: begin
                if (s_accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        start_d = 1'b1;
                        state_d = ST_FIRE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_FIRE: begin
                // n_start_ is high during this single cycle; any n_end_ seen
                // here belongs to an older operation and is ignored.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Done takes priority over the timeout in the final cycle.
                if (n_end_) begin
                    rdata_d  = n_out;
                    rvalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end else if (cnt_q == LAST_CNT) begin
                    terr_d  = 1'b1;
                    state_d = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (r_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_COLLECT;
            idx_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            terr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            rvalid_q <= rvalid_d;
            terr_q   <= terr_d;
            rdata_q  <= rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Weight bank: writable in any state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) begin
                weight_q[k] <= '0;
            end
        end else if (w_write_ok) begin
            weight_q[w_addr[IDX_W-1:0]] <= w_data;
        end
    end

    // ------------------------------------------------------------------------
    // Input sample registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) begin
                sample_q[k] <= '0;
            end
        end else if (s_accept) begin
            sample_q[idx_q] <= s_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pack bank and samples onto the Neurone buses.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < N_IN; k++) begin : g_pack
            assign n_input[k*IN_W +: IN_W] = sample_q[k];
            assign n_weight[k*W_W +: W_W]  = weight_q[k];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign n_start_    = start_q;
    assign r_valid     = rvalid_q;
    assign r_data      = rdata_q;
    assign busy        = (state_q != ST_COLLECT);
    assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_neuron_feeder
// Description : Directed self-checking bench for neuron_feeder with a
//               behavioural Neurone stub (programmable latency, optional
//               silence, forced done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_feeder;

    localparam int N_IN    = 9;
    localparam int IN_W    = 100;
    localparam int W_W     = 33;
    localparam int TIMEOUT = 16;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 w_we    = 1'b0;
    logic [3:0]           w_addr  = '0;
    logic [W_W-1:0]       w_data  = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [IN_W-1:0]      s_data  = '0;
    logic [N_IN*IN_W-1:0] n_input;
    logic [N_IN*W_W-1:0]  n_weight;
    logic                 n_start_;
    logic [IN_W-1:0]      n_out;
    logic                 n_end_;
    logic                 r_valid;
    logic                 r_ready = 1'b0;
    logic [IN_W-1:0]      r_data;
    logic                 busy;
    logic                 timeout_err;

    int errors = 0;
    int checks = 0;

    // bench-side copies of the bank and samples
    logic signed [W_W-1:0]  wt  [N_IN];
    logic signed [IN_W-1:0] smp [N_IN];

    localparam logic signed [IN_W-1:0] T1_RESULT = 100'sd284622056175;

    neuron_feeder #(
        .N_IN    (N_IN),
        .IN_W    (IN_W),
        .W_W     (W_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .n_input     (n_input),
        .n_weight    (n_weight),
        .n_start_    (n_start_),
        .n_out       (n_out),
        .n_end_      (n_end_),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Neurone stub
    // ------------------------------------------------------------------------
    logic            stub_respond   = 1'b1;
    int              stub_lat       = 2;
    logic            stub_force_end = 1'b0;
    logic            stub_busy_q;
    logic            stub_end_q;
    int              stub_cnt_q;
    logic [IN_W-1:0] stub_out_q;

    function automatic logic [IN_W-1:0] neurone_mac(input logic [N_IN*IN_W-1:0] ni,
                                                    input logic [N_IN*W_W-1:0]  nw);
        logic signed [IN_W-1:0] acc;
        logic signed [IN_W-1:0] a;
        logic signed [W_W-1:0]  b;
        acc = '0;
        for (int k = 0; k < N_IN; k++) begin
            a   = ni[k*IN_W +: IN_W];
            b   = nw[k*W_W +: W_W];
            acc = acc + a * b;
        end
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy_q <= 1'b0;
            stub_end_q  <= 1'b0;
            stub_cnt_q  <= 0;
            stub_out_q  <= '0;
        end else begin
            stub_end_q <= 1'b0;
            if (n_start_ === 1'b1) begin
                stub_busy_q <= stub_respond;
                stub_cnt_q  <= stub_lat;
                stub_out_q  <= neurone_mac(n_input, n_weight);
            end else if (stub_busy_q) begin
                if (stub_cnt_q == 0) begin
                    stub_end_q  <= 1'b1;
                    stub_busy_q <= 1'b0;
                end else begin
                    stub_cnt_q <= stub_cnt_q - 1;
                end
            end
        end
    end

    assign n_end_ = stub_end_q | stub_force_end;
    assign n_out  = stub_out_q;

    // count of start pulses seen on rising edges
    int starts = 0;
    always @(posedge clk) begin
        if (n_start_ === 1'b1) starts <= starts + 1;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic signed [IN_W-1:0] model();
        logic signed [IN_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N_IN; k++) acc = acc + smp[k] * wt[k];
        return acc;
    endfunction

    function automatic logic [N_IN*IN_W-1:0] pack_in();
        logic [N_IN*IN_W-1:0] p;
        for (int k = 0; k < N_IN; k++) p[k*IN_W +: IN_W] = smp[k];
        return p;
    endfunction

    function automatic logic [N_IN*W_W-1:0] pack_w();
        logic [N_IN*W_W-1:0] p;
        for (int k = 0; k < N_IN; k++) p[k*W_W +: W_W] = wt[k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_weight(input logic [3:0] a, input logic [W_W-1:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        tick();
        w_we = 1'b0;
    endtask

    task automatic load_bank();
        for (int k = 0; k < N_IN; k++) write_weight(4'(k), wt[k]);
    endtask

    task automatic set_t1();
        wt  = '{33'sd51796937, -33'sd40593016, 33'sd43687913, 33'sd55766463,
                -33'sd8397900, 33'sd44529730, -33'sd53606200, 33'sd23677492,
                -33'sd38560940};
        smp = '{100'sd0, 100'sd0, 100'sd4, 100'sd1, 100'sd294, 100'sd6442,
                100'sd0, 100'sd0, 100'sd0};
    endtask

    // Returns #1 after the accepting edge.
    task automatic send_sample(input logic [IN_W-1:0] d, input int gap);
        int n;
        for (int g = 0; g < gap; g++) tick();
        s_valid = 1'b1; s_data = d; n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL s_ready_wait: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic stream_all(input int max_gap);
        for (int k = 0; k < N_IN; k++) send_sample(smp[k], $urandom_range(max_gap, 0));
    endtask

    task automatic wait_result(output logic [IN_W-1:0] d);
        int n;
        n = 0;
        while (r_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL result_wait: r_valid=%b after %0d cycles, required 1", r_valid, n);
        end
        d = r_data;
    endtask

    task automatic accept_result();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({n_start_, r_valid, busy, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: start/rvalid/busy/terr=%b, required 0000",
                     {n_start_, r_valid, busy, timeout_err});
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %b, required 1", s_ready);
        end
        checks++;
        if (r_data !== '0 || n_input !== '0 || n_weight !== '0) begin
            errors++; $display("FAIL reset_data: r_data/n_input/n_weight not all zero");
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [IN_W-1:0] res;
        int s0;
        set_t1();
        load_bank();
        checks++;
        if (n_weight !== pack_w()) begin
            errors++; $display("FAIL t1_bank: n_weight=%h, required %h", n_weight, pack_w());
        end
        s0 = starts;
        stream_all(0);
        checks++;
        if (n_start_ !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL t1_fire: n_start_=%b s_ready=%b, required 1 0", n_start_, s_ready);
        end
        tick();
        checks++;
        if (n_start_ !== 1'b0) begin
            errors++; $display("FAIL t1_pulse_width: n_start_=%b, required 0", n_start_);
        end
        wait_result(res);
        checks++;
        if (res !== T1_RESULT || res !== model()) begin
            errors++;
            $display("FAIL t1_result: r_data=%0d, required %0d", $signed(res), T1_RESULT);
        end
        checks++;
        if (starts - s0 != 1) begin
            errors++; $display("FAIL t1_start_count: got %0d pulses, required 1", starts - s0);
        end
        accept_result();
        checks++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_release: r_valid=%b s_ready=%b busy=%b, required 0 1 0",
                     r_valid, s_ready, busy);
        end
    endtask

    task automatic test_hold();
        logic [IN_W-1:0] res;
        int s0;
        int bad;
        s0 = starts;
        stream_all(0);
        wait_result(res);
        s_valid = 1'b1; s_data = 100'd123;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (r_valid !== 1'b1 || r_data !== res || s_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        s_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL t2_hold_stable: %0d unstable cycles, required 0", bad);
        end
        checks++;
        if (res !== T1_RESULT) begin
            errors++;
            $display("FAIL t2_result: r_data=%0d, required %0d", $signed(res), T1_RESULT);
        end
        checks++;
        if (starts - s0 != 1) begin
            errors++; $display("FAIL t2_start_count: got %0d pulses, required 1", starts - s0);
        end
        accept_result();
        checks++;
        if (n_input !== pack_in()) begin
            errors++; $display("FAIL t2_no_accept: n_input changed while held");
        end
    endtask

    task automatic test_timeout();
        int early;
        int rv;
        stub_respond = 1'b0;
        stream_all(0);
        tick();                        // WAIT entered on this edge
        early = 0; rv = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if (timeout_err !== 1'b0) early++;
            if (r_valid !== 1'b0) rv++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL t3_early: timeout_err high %0d cycles early", early);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL t3_timeout: timeout_err=%b, required 1", timeout_err);
        end
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0 || rv != 0) begin
            errors++;
            $display("FAIL t3_return: s_ready=%b busy=%b r_valid=%b rv_cycles=%0d, required 1 0 0 0",
                     s_ready, busy, r_valid, rv);
        end
        checks++;
        if (n_input !== pack_in()) begin
            errors++; $display("FAIL t3_inputs_kept: n_input differs from last samples");
        end
        repeat (3) tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL t3_sticky: timeout_err=%b, required 1", timeout_err);
        end
        stub_respond = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0] res;
        int rv;
        stub_lat = 10;
        stream_all(0);
        repeat (3) tick();             // inside WAIT
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({n_start_, r_valid, busy, timeout_err} !== 4'b0000 || r_data !== '0) begin
            errors++;
            $display("FAIL t4_async: start/rvalid/busy/terr=%b r_data=%0d, required 0000 0",
                     {n_start_, r_valid, busy, timeout_err}, r_data);
        end
        checks++;
        if (n_input !== '0 || n_weight !== '0) begin
            errors++; $display("FAIL t4_regs_cleared: n_input/n_weight not zero");
        end
        tick();
        rst_n = 1'b1;
        stub_lat = 2;
        rv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (r_valid !== 1'b0) rv++;
        end
        checks++;
        if (rv != 0) begin
            errors++; $display("FAIL t4_discard: r_valid high %0d cycles, required 0", rv);
        end
        set_t1();
        load_bank();
        stream_all(0);
        wait_result(res);
        checks++;
        if (res !== T1_RESULT) begin
            errors++;
            $display("FAIL t4_rerun: r_data=%0d, required %0d", $signed(res), T1_RESULT);
        end
        accept_result();
    endtask

    task automatic test_guard();
        logic [N_IN*W_W-1:0] snap;
        logic [IN_W-1:0]     res;
        snap = n_weight;
        write_weight(4'd9, 33'h1_5555_5555);
        write_weight(4'd15, 33'h0_AAAA_AAAA);
        checks++;
        if (n_weight !== snap) begin
            errors++; $display("FAIL t5_addr_guard: n_weight=%h, required %h", n_weight, snap);
        end
        smp = '{-100'sd7, 100'sd13, 100'sd0, 100'sd5, -100'sd300, 100'sd21,
                100'sd8, -100'sd2, 100'sd99};
        stub_lat = 3;
        stream_all(0);
        stub_force_end = 1'b1;         // DUT is in FIRE now
        tick();
        stub_force_end = 1'b0;
        checks++;
        if (r_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_fire_end: r_valid=%b busy=%b, required 0 1", r_valid, busy);
        end
        wait_result(res);
        checks++;
        if (res !== model()) begin
            errors++;
            $display("FAIL t5_result: r_data=%0d, required %0d", $signed(res), model());
        end
        accept_result();
        stub_lat = 2;
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0] res;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < N_IN; k++) begin
                wt[k]  = W_W'(longint'((k % 2 == 1) ? -1 : 1) * longint'(1000 + 7919*k + 104729*t));
                smp[k] = IN_W'(longint'(((k + t) % 3 == 0) ? -1 : 1) * longint'(3 + 131*k*(t + 1)));
            end
            load_bank();
            stream_all(3);
            checks++;
            if (n_input !== pack_in()) begin
                errors++; $display("FAIL t6_order_%0d: n_input=%h, required %h", t, n_input, pack_in());
            end
            wait_result(res);
            checks++;
            if (res !== model()) begin
                errors++;
                $display("FAIL t6_result_%0d: r_data=%0d, required %0d", t, $signed(res), model());
            end
            repeat ($urandom_range(3, 0)) tick();
            accept_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_guard();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
